// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one single-port RAM between the CPU and a program/DMA
//            loader. Fixed CPU priority, starvation promotion for the
//            loader and a loader burst lock.
// Ports    : clk, rst (async, active-low)
//            cpu_req/we/addr/wdata -> cpu_ack, cpu_rdata
//            ldr_req/we/addr/wdata/lock -> ldr_ack, ldr_rdata
//            MemRW/MemAddr/MemD -> RAM, MemQ <- RAM (combinational read)
//            owner : 00 none, 01 CPU, 10 loader
// Revision : 1.0  initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int AW         = 8,
  parameter int DW         = 16,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ack,
  output logic [DW-1:0] cpu_rdata,
  input  logic          ldr_req,
  input  logic          ldr_we,
  input  logic [AW-1:0] ldr_addr,
  input  logic [DW-1:0] ldr_wdata,
  input  logic          ldr_lock,
  output logic          ldr_ack,
  output logic [DW-1:0] ldr_rdata,
  output logic          MemRW,
  output logic [AW-1:0] MemAddr,
  output logic [DW-1:0] MemD,
  input  logic [DW-1:0] MemQ,
  output logic [1:0]    owner
);

  localparam logic [3:0] C_STARVE_MAX = 4'(STARVE_MAX);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_we;
  logic          r_sel;        // 0 = CPU owns the transaction, 1 = loader
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_d;
  logic [DW-1:0] r_cpu_rdata;
  logic [DW-1:0] r_ldr_rdata;
  logic [3:0]    r_ldr_wait;
  logic          r_lock_q;

  logic          w_ldr_starved;
  logic          w_grant_ldr;
  logic          w_grant_cpu;
  logic          w_grant;

  // Loader wins when it holds the lock, when it has been starved, or when
  // the CPU is not asking. A held lock also blocks the CPU even if the
  // loader has let go of req for this arbitration.
  assign w_ldr_starved = (r_ldr_wait == C_STARVE_MAX);
  assign w_grant_ldr   = ldr_req & (r_lock_q | w_ldr_starved | ~cpu_req);
  assign w_grant_cpu   = cpu_req & ~r_lock_q & ~w_grant_ldr;
  assign w_grant       = w_grant_ldr | w_grant_cpu;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // MemRW is decoded from the state register so an asynchronous reset
  // removes the write strobe immediately.
  always_comb begin
    w_state_nxt = r_state;
    MemRW       = 1'b0;
    cpu_ack     = 1'b0;
    ldr_ack     = 1'b0;
    owner       = 2'b00;
    case (r_state)
      ST_IDLE: begin
        if (w_grant) begin
          w_state_nxt = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        w_state_nxt = ST_DONE;
        MemRW       = r_we;
        owner       = r_sel ? 2'b10 : 2'b01;
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
        cpu_ack     = ~r_sel;
        ldr_ack     = r_sel;
        owner       = r_sel ? 2'b10 : 2'b01;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_we        <= 1'b0;
      r_sel       <= 1'b0;
      r_addr      <= '0;
      r_d         <= '0;
      r_cpu_rdata <= '0;
      r_ldr_rdata <= '0;
      r_ldr_wait  <= 4'd0;
      r_lock_q    <= 1'b0;
    end else begin
      if (r_state == ST_IDLE) begin
        if (w_grant) begin
          r_sel  <= w_grant_ldr;
          r_we   <= w_grant_ldr ? ldr_we    : cpu_we;
          r_addr <= w_grant_ldr ? ldr_addr  : cpu_addr;
          r_d    <= w_grant_ldr ? ldr_wdata : cpu_wdata;
        end
        if (w_grant_ldr) begin
          r_ldr_wait <= 4'd0;
        end else if (w_grant_cpu && ldr_req && !w_ldr_starved) begin
          r_ldr_wait <= r_ldr_wait + 4'd1;
        end
        if (w_grant_ldr && ldr_lock) begin
          r_lock_q <= 1'b1;
        end else if (!ldr_lock || !ldr_req) begin
          r_lock_q <= 1'b0;
        end
      end
      // Read data is captured at the edge that ends the RAM access.
      if (r_state == ST_ACCESS && !r_we) begin
        if (r_sel) begin
          r_ldr_rdata <= MemQ;
        end else begin
          r_cpu_rdata <= MemQ;
        end
      end
    end
  end

  assign MemAddr   = r_addr;
  assign MemD      = r_d;
  assign cpu_rdata = r_cpu_rdata;
  assign ldr_rdata = r_ldr_rdata;

endmodule
`default_nettype wire
